// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer driving all control lines of the 8-bit core
module control_sequencer #(
  parameter int OP_W      = 4,
  parameter int STEP_W    = 3,
  parameter int EARLY_END = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic              zf,
  input  logic              cf,
  output logic              hlt,
  output logic              mi,
  output logic              ri,
  output logic              ro,
  output logic              io,
  output logic              ii,
  output logic              ai,
  output logic              ao,
  output logic              eo,
  output logic              su,
  output logic              fi,
  output logic              bi,
  output logic              oi,
  output logic              ce,
  output logic              co,
  output logic              j,
  output logic [STEP_W-1:0] step,
  output logic              halted
);
  localparam logic [3:0] NOP = 4'h0, LDA = 4'h1, ADD = 4'h2, SUB = 4'h3, STA = 4'h4, LDI = 4'h5,
                         JMP = 4'h6, JC = 4'h7, JZ = 4'h8, OUT = 4'hE, HLT = 4'hF;
  localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000, C_RO = 16'h1000,
                          C_IO = 16'h0800, C_II = 16'h0400, C_AI = 16'h0200, C_AO = 16'h0100,
                          C_EO = 16'h0080, C_SU = 16'h0040, C_FI = 16'h0020, C_BI = 16'h0010,
                          C_OI = 16'h0008, C_CE = 16'h0004, C_CO = 16'h0002, C_J  = 16'h0001;
  logic [3:0] op;
  logic [STEP_W-1:0] last;
  logic [15:0] c;
  assign op = opcode[3:0];
  // last active step of the current instruction, used to end short instructions early
  always_comb
    last = (op == ADD || op == SUB) ? STEP_W'(4) :
           (op == LDA || op == STA) ? STEP_W'(3) :
           (op inside {LDI, JMP, JC, JZ, OUT, HLT}) ? STEP_W'(2) : STEP_W'(1);
  // step counter and halt latch; halt freezes the counter at T2 until reset
  always_ff @(posedge clk)
    if (rst) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step > STEP_W'(4)) step <= STEP_W'(1);
      else if (step == STEP_W'(2) && op == HLT) halted <= 1'b1;
      else if ((EARLY_END != 0 && step == last) || step == STEP_W'(4)) step <= '0;
      else step <= step + STEP_W'(1);
    end
  // microcode decode; reset silences every line so nothing drives the bus
  always_comb begin
    c = '0;
    if (rst) c = '0;
    else if (halted) c = C_HLT;
    else
      case (step)
        STEP_W'(1): c = C_RO | C_II | C_CE;
        STEP_W'(2):
          case (op)
            LDA, ADD, SUB, STA: c = C_IO | C_MI;
            LDI:                c = C_IO | C_AI;
            JMP:                c = C_IO | C_J;
            JC:                 c = cf ? C_IO | C_J : C_IO;
            JZ:                 c = zf ? C_IO | C_J : C_IO;
            OUT:                c = C_AO | C_OI;
            HLT:                c = C_HLT;
            default:            c = '0;
          endcase
        STEP_W'(3):
          case (op)
            LDA:      c = C_RO | C_AI;
            ADD, SUB: c = C_RO | C_BI;
            STA:      c = C_AO | C_RI;
            default:  c = '0;
          endcase
        STEP_W'(4):
          c = (op == ADD) ? C_EO | C_AI | C_FI :
              (op == SUB) ? C_EO | C_AI | C_FI | C_SU : '0;
        default: c = C_CO | C_MI;
      endcase
  end
  assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, fi, bi, oi, ce, co, j} = c;
endmodule
